// File: rtl/cpu_pkg.sv
// Shared core constants and typedefs used by the register file and scoreboard.
package cpu_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits (flush > issue > retire) and a registered popcount of them.
module reg_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    input  logic                ret_en,
    input  logic [ADDR_W-1:0]   ret_addr,
    input  logic                flush,
    output logic [2**ADDR_W-1:0] pend,
    output logic [ADDR_W:0]     pend_cnt
);
    import cpu_pkg::*;

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] pend_nxt;
    logic [ADDR_W:0]  cnt_nxt;
    logic             iss_ok;

    assign iss_ok = iss_en && !(ZERO_REG && iss_addr == ADDR_W'(REG_ZERO));

    // Clear before set so a same-index issue (younger producer) wins over the retire.
    always_comb begin
        pend_nxt = pend;
        if (flush) begin
            pend_nxt = '0;
        end else begin
            if (ret_en) pend_nxt[ret_addr] = 1'b0;
            if (iss_ok) pend_nxt[iss_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// 2R/1W register file with same-cycle write bypass and a pending-producer scoreboard.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   pend_cnt
);
    import cpu_pkg::*;

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic              wr_ok;
    logic              rs_byp, rt_byp;

    // Writes to the hardwired zero register never land, so mem[0] stays 0.
    assign wr_ok = wr_en && !(ZERO_REG && wr_addr == ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Bypass is held off during reset so the read ports show the cleared array.
    assign rs_byp  = rst_n && wr_ok && wr_addr == rs_addr;
    assign rt_byp  = rst_n && wr_ok && wr_addr == rt_addr;
    assign rs_data = rs_byp ? wr_data : mem[rs_addr];
    assign rt_data = rt_byp ? wr_data : mem[rt_addr];

    assign rs_busy = pend[rs_addr] && !(wr_en && wr_addr == rs_addr);
    assign rt_busy = pend[rt_addr] && !(wr_en && wr_addr == rt_addr);

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .ret_en   (wr_en),
        .ret_addr (wr_addr),
        .flush    (flush),
        .pend     (pend),
        .pend_cnt (pend_cnt)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard against an array/flag model, plus directed literal checks.
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs_addr, rt_addr, wr_addr, iss_addr;
    logic [DW-1:0] rs_data, rt_data, wr_data;
    logic          rs_busy, rt_busy, wr_en, iss_en, flush;
    logic [AW:0]   pend_cnt;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [DW-1:0] m_reg [N];
    bit            m_pend [N];

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (rst_n && wr_en && wr_addr == a && a != 0) return wr_data;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        return m_pend[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            end else begin
                if (wr_en) m_pend[wr_addr] = 1'b0;
                if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
            end
        end
    end

    // Single compare process: every negedge, outputs vs model.
    always @(negedge clk) begin
        chk("m_rs_data", 64'(rs_data), 64'(exp_data(rs_addr)));
        chk("m_rt_data", 64'(rt_data), 64'(exp_data(rt_addr)));
        chk("m_rs_busy", 64'(rs_busy), 64'(exp_busy(rs_addr)));
        chk("m_rt_busy", 64'(rt_busy), 64'(exp_busy(rt_addr)));
        chk("m_pend_cnt", 64'(pend_cnt), 64'(exp_cnt()));
    end

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] raddr();
        return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, N-1));
    endfunction

    initial begin
        rst_n = 1'b0; wr_en = 0; iss_en = 0; flush = 0;
        rs_addr = 0; rt_addr = 0; wr_addr = 0; iss_addr = 0; wr_data = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        chk("reset_rs_data", 64'(rs_data), 64'd0);
        chk("reset_pend_cnt", 64'(pend_cnt), 64'd0);

        edge_drive(); wr_en = 1; wr_addr = 8; wr_data = 32'hDEADBEEF;
        edge_drive(); wr_en = 0; rs_addr = 8; #2;
        chk("write_read_r8", 64'(rs_data), 64'hDEADBEEF);

        edge_drive(); wr_en = 1; wr_addr = 9; wr_data = 32'h1234; rs_addr = 9; #2;
        chk("bypass_r9", 64'(rs_data), 64'h1234);

        edge_drive(); wr_addr = 0; wr_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; rs_addr = 0; #2;
        chk("zero_bypass", 64'(rs_data), 64'd0);
        edge_drive(); wr_en = 0; iss_en = 0; #2;
        chk("zero_data", 64'(rs_data), 64'd0);
        chk("zero_busy", 64'(rs_busy), 64'd0);
        chk("zero_cnt", 64'(pend_cnt), 64'd0);

        edge_drive(); iss_en = 1; iss_addr = 3;
        edge_drive(); iss_addr = 4;
        edge_drive(); iss_en = 0; rs_addr = 3; #2;
        chk("sb_cnt2", 64'(pend_cnt), 64'd2);
        chk("sb_busy_r3", 64'(rs_busy), 64'd1);

        edge_drive(); wr_en = 1; wr_addr = 3; wr_data = 32'h33; iss_en = 1; iss_addr = 3;
        edge_drive(); wr_en = 0; iss_en = 0; #2;
        chk("same_idx_busy", 64'(rs_busy), 64'd1);
        chk("same_idx_cnt", 64'(pend_cnt), 64'd2);

        edge_drive(); wr_en = 1; wr_addr = 4; wr_data = 32'h44;
        edge_drive(); wr_en = 0; #2;
        chk("retire_r4_cnt", 64'(pend_cnt), 64'd1);

        edge_drive(); iss_en = 1; iss_addr = 5;
        edge_drive(); iss_addr = 6;
        edge_drive(); iss_addr = 7; flush = 1;
        edge_drive(); iss_en = 0; flush = 0; rs_addr = 5; rt_addr = 7; #2;
        chk("flush_cnt", 64'(pend_cnt), 64'd0);
        chk("flush_rs_busy", 64'(rs_busy), 64'd0);
        chk("flush_rt_busy", 64'(rt_busy), 64'd0);

        edge_drive(); wr_en = 1; wr_addr = 5; wr_data = 32'h5555;
        edge_drive(); wr_en = 0; #2;
        chk("post_flush_write", 64'(rs_data), 64'h5555);

        for (int c = 0; c < 3000; c++) begin
            edge_drive();
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_addr  = raddr();
            wr_data  = $urandom;
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_addr = raddr();
            flush    = ($urandom_range(0, 31) == 0);
            rs_addr  = raddr();
            rt_addr  = raddr();
        end

        // Load known state, then drop reset between edges.
        edge_drive(); flush = 0; wr_en = 1; wr_addr = 12; wr_data = 32'hCAFE0012; iss_en = 1; iss_addr = 13;
        edge_drive(); wr_en = 0; iss_en = 0; rs_addr = 12; rt_addr = 13; #2;
        chk("pre_reset_data", 64'(rs_data), 64'hCAFE0012);
        chk("pre_reset_busy", 64'(rt_busy), 64'd1);
        rst_n = 1'b0; #1;
        chk("async_rs_data", 64'(rs_data), 64'd0);
        chk("async_rt_busy", 64'(rt_busy), 64'd0);
        chk("async_cnt", 64'(pend_cnt), 64'd0);
        edge_drive(); rst_n = 1'b1;

        for (int c = 0; c < 200; c++) begin
            edge_drive();
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = raddr();
            wr_data  = $urandom;
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_addr = raddr();
            flush    = ($urandom_range(0, 15) == 0);
            rs_addr  = raddr();
            rt_addr  = raddr();
        end
        edge_drive(); wr_en = 0; iss_en = 0; flush = 0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
